// File: rtl/sram_chain_signature_checker_if.sv
// ============================================================================
// Module   : sram_chain_signature_checker_if
// Brief    : Control/data bundle between a run controller and the chain
//            signature checker.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sram_chain_signature_checker_if;
    logic        start;
    logic        sample_en;
    logic [7:0]  chain_q;
    logic [15:0] golden_sig;
    logic [15:0] sig_out;
    logic [7:0]  frame_cnt;
    logic        busy;
    logic        done;
    logic        pass;
    logic        div_out;
    logic        stuck;

    modport master (
        output start, sample_en, chain_q, golden_sig,
        input  sig_out, frame_cnt, busy, done, pass, div_out, stuck
    );

    modport slave (
        input  start, sample_en, chain_q, golden_sig,
        output sig_out, frame_cnt, busy, done, pass, div_out, stuck
    );
endinterface

`default_nettype wire

// File: rtl/sram_chain_signature_checker.sv
// ============================================================================
// Module   : sram_chain_signature_checker
// Brief    : Compresses the SRAM clock-chain divider bus into a 16-bit MISR
//            over NUM_FRAMES 8-beat frames and checks it against a golden
//            value. Optional stuck-chain detection: define STUCK_DETECT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_chain_signature_checker #(
    parameter int          NUM_FRAMES  = 4,
    parameter logic [15:0] SEED        = 16'hFFFF,
    parameter int          STUCK_LIMIT = 16
) (
    input  wire logic                     gated_clk,
    input  wire logic                     rst,
    sram_chain_signature_checker_if.slave bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_COMPARE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [7:0] c_LAST_FRAME = 8'(NUM_FRAMES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [15:0] r_sig;
    logic [7:0]  r_frame_cnt;
    logic [2:0]  r_beat;
    logic        r_pass;
    logic        r_div;
    logic        w_busy;
    logic        w_done;

    logic        w_load;
    logic        w_beat_ok;
    logic        w_frame_end;
    logic        w_last_frame;
    logic        w_fb;
    logic [15:0] w_misr_next;

    // A new run may only be launched from the two quiescent states.
    assign w_load       = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_beat_ok    = (r_state == S_RUN) && bus.sample_en;
    assign w_frame_end  = w_beat_ok && (r_beat == 3'd7);
    assign w_last_frame = w_frame_end && (r_frame_cnt == c_LAST_FRAME);

    assign w_fb        = r_sig[15] ^ r_sig[13] ^ r_sig[12] ^ r_sig[10];
    assign w_misr_next = {r_sig[14:0], w_fb} ^ {8'h00, bus.chain_q};

    always_ff @(posedge gated_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_next_state = S_RUN;
            S_RUN:     if (w_last_frame) w_next_state = S_COMPARE;
            S_COMPARE: w_next_state = S_DONE;
            S_DONE:    if (bus.start) w_next_state = S_RUN;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN, S_COMPARE: w_busy = 1'b1;
            S_DONE:           w_done = 1'b1;
            default:          ;
        endcase
    end

    always_ff @(posedge gated_clk or posedge rst) begin
        if (rst) begin
            r_sig       <= SEED;
            r_frame_cnt <= 8'd0;
            r_beat      <= 3'd0;
            r_pass      <= 1'b0;
            r_div       <= 1'b0;
        end else if (w_load) begin
            r_sig       <= SEED;
            r_frame_cnt <= 8'd0;
            r_beat      <= 3'd0;
            r_pass      <= 1'b0;
        end else if (w_beat_ok) begin
            r_sig  <= w_misr_next;
            r_beat <= r_beat + 3'd1;
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_div       <= ~r_div;
            end
        end else if (r_state == S_COMPARE) begin
            r_pass <= (r_sig == bus.golden_sig);
        end
    end

`ifdef STUCK_DETECT_EN
    localparam int             c_CW        = $clog2(STUCK_LIMIT + 1);
    localparam logic [c_CW-1:0] c_RUN_LIMIT = c_CW'(STUCK_LIMIT - 1);

    logic [7:0]      r_prev;
    logic [c_CW-1:0] r_run_len;
    logic [c_CW-1:0] w_run_len_next;
    logic            r_stuck;

    // Run length saturates at the flag threshold so it can never wrap.
    always_comb begin
        w_run_len_next = {c_CW{1'b0}};
        if (bus.chain_q == r_prev) begin
            w_run_len_next = (r_run_len == c_RUN_LIMIT) ? r_run_len : r_run_len + 1'b1;
        end
    end

    always_ff @(posedge gated_clk or posedge rst) begin
        if (rst) begin
            r_prev    <= 8'h00;
            r_run_len <= {c_CW{1'b0}};
            r_stuck   <= 1'b0;
        end else if (w_load) begin
            r_prev    <= 8'h00;
            r_run_len <= {c_CW{1'b0}};
            r_stuck   <= 1'b0;
        end else if (w_beat_ok) begin
            r_prev    <= bus.chain_q;
            r_run_len <= w_run_len_next;
            if (w_run_len_next == c_RUN_LIMIT) r_stuck <= 1'b1;
        end
    end

    assign bus.stuck = r_stuck;
`else
    // Constant zero for any legal limit; keeps the parameter referenced.
    assign bus.stuck = (STUCK_LIMIT < 0);
`endif

    assign bus.sig_out   = r_sig;
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.pass      = r_pass;
    assign bus.div_out   = r_div;

endmodule

`default_nettype wire

// File: tb/tb_sram_chain_signature_checker.sv
// ============================================================================
// Module   : tb_sram_chain_signature_checker
// Brief    : Directed, table-driven bench for sram_chain_signature_checker
//            using three instances (NUM_FRAMES = 1, 2, 4) on shared stimulus.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_chain_signature_checker;

    logic        gated_clk = 1'b0;
    logic        rst       = 1'b1;
    logic        r_start   = 1'b0;
    logic        r_sample_en = 1'b0;
    logic [7:0]  r_chain_q = 8'h00;
    logic [15:0] r_golden  = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef STUCK_DETECT_EN
    localparam logic c_STUCK_EXP = 1'b1;
`else
    localparam logic c_STUCK_EXP = 1'b0;
`endif

    always #5 gated_clk = ~gated_clk;

    sram_chain_signature_checker_if u_if1 ();
    sram_chain_signature_checker_if u_if2 ();
    sram_chain_signature_checker_if u_if4 ();

    assign u_if1.start = r_start;  assign u_if1.sample_en = r_sample_en;
    assign u_if1.chain_q = r_chain_q;  assign u_if1.golden_sig = r_golden;
    assign u_if2.start = r_start;  assign u_if2.sample_en = r_sample_en;
    assign u_if2.chain_q = r_chain_q;  assign u_if2.golden_sig = r_golden;
    assign u_if4.start = r_start;  assign u_if4.sample_en = r_sample_en;
    assign u_if4.chain_q = r_chain_q;  assign u_if4.golden_sig = r_golden;

    sram_chain_signature_checker #(.NUM_FRAMES(1)) u_dut1 (
        .gated_clk(gated_clk), .rst(rst), .bus(u_if1));
    sram_chain_signature_checker #(.NUM_FRAMES(2)) u_dut2 (
        .gated_clk(gated_clk), .rst(rst), .bus(u_if2));
    sram_chain_signature_checker #(.NUM_FRAMES(4)) u_dut4 (
        .gated_clk(gated_clk), .rst(rst), .bus(u_if4));

    typedef struct {
        logic [7:0]  chain;
        logic [15:0] golden;
        logic [15:0] exp_sig;
        logic        exp_pass;
    } vec_t;

    vec_t vt[4];

    task automatic tick();
        @(posedge gated_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_start();
        r_start     = 1'b1;
        r_sample_en = 1'b0;
        tick();
        r_start     = 1'b0;
    endtask

    task automatic beats(input int n, input logic [7:0] v);
        r_sample_en = 1'b1;
        r_chain_q   = v;
        repeat (n) tick();
        r_sample_en = 1'b0;
    endtask

    initial begin
        int n;

        vt[0] = '{chain: 8'h00, golden: 16'hFF00, exp_sig: 16'hFF00, exp_pass: 1'b1};
        vt[1] = '{chain: 8'h00, golden: 16'hFF01, exp_sig: 16'hFF00, exp_pass: 1'b0};
        vt[2] = '{chain: 8'hFF, golden: 16'hAA5C, exp_sig: 16'hAA5C, exp_pass: 1'b1};
        vt[3] = '{chain: 8'hFF, golden: 16'h0000, exp_sig: 16'hAA5C, exp_pass: 1'b0};

        // Reset state
        do_reset();
        chk("rst_sig", u_if4.sig_out, 16'hFFFF);
        chk("rst_frame", u_if4.frame_cnt, 8'd0);
        chk("rst_busy", u_if4.busy, 1'b0);
        chk("rst_done", u_if4.done, 1'b0);
        chk("rst_pass", u_if4.pass, 1'b0);
        chk("rst_div", u_if4.div_out, 1'b0);
        chk("rst_stuck", u_if4.stuck, 1'b0);

        // Divided clock on the two-frame instance, with start pulses in RUN
        do_start();
        beats(4, 8'h00);
        r_start = 1'b1;
        beats(1, 8'h00);
        r_start = 1'b0;
        beats(2, 8'h00);
        chk("div_beat7", u_if2.div_out, 1'b0);
        beats(1, 8'h00);
        chk("div_beat8", u_if2.div_out, 1'b1);
        chk("frame_beat8", u_if2.frame_cnt, 8'd1);
        beats(7, 8'h00);
        chk("div_beat15", u_if2.div_out, 1'b1);
        r_start = 1'b1;
        beats(1, 8'h00);
        r_start = 1'b0;
        chk("div_beat16", u_if2.div_out, 1'b0);
        chk("frame_beat16", u_if2.frame_cnt, 8'd2);
        chk("busy_compare", u_if2.busy, 1'b1);
        chk("done_compare", u_if2.done, 1'b0);
        tick();
        chk("done_two_frame", u_if2.done, 1'b1);

        // Table-driven single-frame runs
        do_reset();
        for (int i = 0; i < 4; i++) begin
            r_golden = vt[i].golden;
            do_start();
            beats(8, vt[i].chain);
            chk($sformatf("v%0d_sig", i), u_if1.sig_out, vt[i].exp_sig);
            chk($sformatf("v%0d_busy", i), u_if1.busy, 1'b1);
            chk($sformatf("v%0d_notdone", i), u_if1.done, 1'b0);
            tick();
            chk($sformatf("v%0d_done", i), u_if1.done, 1'b1);
            chk($sformatf("v%0d_pass", i), u_if1.pass, vt[i].exp_pass);
            chk($sformatf("v%0d_idle", i), u_if1.busy, 1'b0);
            tick();
            chk($sformatf("v%0d_pass_hold", i), u_if1.pass, vt[i].exp_pass);
            chk($sformatf("v%0d_sig_hold", i), u_if1.sig_out, vt[i].exp_sig);
        end

        // Stall after beat 3 for five cycles
        r_golden = 16'hFF00;
        do_start();
        beats(3, 8'h00);
        chk("stall_sig_b3", u_if1.sig_out, 16'hFFF8);
        repeat (5) tick();
        chk("stall_sig_hold", u_if1.sig_out, 16'hFFF8);
        chk("stall_frame_hold", u_if1.frame_cnt, 8'd0);
        beats(5, 8'h00);
        n = 13;
        while (!u_if1.done && n < 40) begin
            tick();
            n++;
        end
        chk("stall_latency", n, 14);
        chk("stall_pass", u_if1.pass, 1'b1);
        chk("stall_sig_final", u_if1.sig_out, 16'hFF00);

        // Asynchronous reset in the middle of a four-frame run
        do_reset();
        do_start();
        beats(13, 8'hA5);
        chk("mid_frame", u_if4.frame_cnt, 8'd1);
        chk("mid_div", u_if4.div_out, 1'b1);
        chk("mid_busy", u_if4.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_sig", u_if4.sig_out, 16'hFFFF);
        chk("arst_frame", u_if4.frame_cnt, 8'd0);
        chk("arst_busy", u_if4.busy, 1'b0);
        chk("arst_done", u_if4.done, 1'b0);
        chk("arst_div", u_if4.div_out, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Stuck chain: constant A5 through a four-frame run
        do_start();
        beats(10, 8'hA5);
        chk("stuck_b10", u_if4.stuck, 1'b0);
        beats(7, 8'hA5);
        chk("stuck_b17", u_if4.stuck, c_STUCK_EXP);
        beats(15, 8'hA5);
        tick();
        chk("stuck_done", u_if4.done, 1'b1);
        chk("stuck_in_done", u_if4.stuck, c_STUCK_EXP);
        do_start();
        chk("stuck_cleared", u_if4.stuck, 1'b0);
        chk("restart_busy", u_if4.busy, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
